// File: rtl/mod_n_down_timer_pkg.sv
// ============================================================================
// Module   : mod_n_down_timer_pkg
// Brief    : Shared types and constants for the modulo-N down timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_n_down_timer_pkg;

  // Controller states of the down timer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default modulus, shared with the mod-12 up-counter.
  localparam int MODULUS_DEFAULT = 12;

  // Highest legal count for the default modulus.
  localparam int MAX_COUNT = MODULUS_DEFAULT - 1;

endpackage : mod_n_down_timer_pkg

`default_nettype wire

// File: rtl/mod_n_down_timer.sv
// ============================================================================
// Module   : mod_n_down_timer
// Brief    : Loadable modulo-N down-counter with terminal-count pulse and
//            optional auto-reload. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_down_timer
  import mod_n_down_timer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  // Top of the legal count range; also the reload value and the clamp ceiling.
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;
  logic [WIDTH-1:0] w_load_clamped;

  // Out-of-range start values saturate to the top of the range.
  assign w_load_clamped = (load_value > c_max) ? c_max : load_value;

  // Next-state and datapath decision; tc defaults low so it only ever pulses.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // en and stop have no effect here; only a load moves us on.
        if (load_valid && r_load_ready) begin
          w_count_next = w_load_clamped;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (en) begin
          if (r_count != '0) begin
            w_count_next = r_count - WIDTH'(1);
          end else begin
            // Zero crossing: the only place auto_reload is looked at.
            w_tc_next = 1'b1;
            if (auto_reload) begin
              w_count_next = c_max;
            end else begin
              w_state_next = ST_DONE;
            end
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, count and status flags; status is registered from the next state
  // so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_tc         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_tc         <= w_tc_next;
      r_busy       <= (w_state_next == ST_RUN);
      r_done       <= (w_state_next == ST_DONE);
      r_load_ready <= (w_state_next != ST_RUN);
    end
  end

  assign count      = r_count;
  assign tc         = r_tc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

endmodule : mod_n_down_timer

`default_nettype wire

// File: tb/tb_mod_n_down_timer.sv
// ============================================================================
// Module   : tb_mod_n_down_timer
// Brief    : Directed self-checking bench for mod_n_down_timer (N=12, W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_n_down_timer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_value;
  logic       en;
  logic       stop;
  logic       auto_reload;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  mod_n_down_timer #(
    .WIDTH  (4),
    .MODULUS(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .en         (en),
    .stop       (stop),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare the full output vector in one go.
  task automatic chk_all(input string tag, input int e_count, input int e_tc,
                         input int e_busy, input int e_done, input int e_ready);
    chk({tag, ".count"},      int'(count),      e_count);
    chk({tag, ".tc"},         int'(tc),         e_tc);
    chk({tag, ".busy"},       int'(busy),       e_busy);
    chk({tag, ".done"},       int'(done),       e_done);
    chk({tag, ".load_ready"}, int'(load_ready), e_ready);
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = 4'd0;
    en = 1'b0; stop = 1'b0; auto_reload = 1'b0;

    // Reset then idle
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 1);
    rst = 1'b0;
    en = 1'b1; stop = 1'b1;
    tick();
    chk_all("idle_ignores_en_stop", 0, 0, 0, 0, 1);
    stop = 1'b0;

    // One-shot count of 5
    load_valid = 1'b1; load_value = 4'd5; auto_reload = 1'b0; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("oneshot_load", 5, 0, 1, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk_all($sformatf("oneshot_cnt%0d", i), i, 0, 1, 0, 0);
    end
    tick();
    chk_all("oneshot_tc", 0, 1, 0, 1, 1);
    tick();
    chk_all("oneshot_done_hold", 0, 0, 0, 1, 1);

    // Auto-reload wrap, loaded from DONE
    load_valid = 1'b1; load_value = 4'd2; auto_reload = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("auto_load", 2, 0, 1, 0, 0);
    tick(); chk_all("auto_cnt1", 1, 0, 1, 0, 0);
    tick(); chk_all("auto_cnt0", 0, 0, 1, 0, 0);
    tick(); chk_all("auto_wrap1", 11, 1, 1, 0, 0);
    for (int i = 10; i >= 0; i--) begin
      tick();
      chk_all($sformatf("auto_cnt%0d", i), i, 0, 1, 0, 0);
    end
    tick(); chk_all("auto_wrap2", 11, 1, 1, 0, 0);

    // Stop back to IDLE, count holds
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("stop_from_auto", 11, 0, 0, 0, 1);

    // Clamp and enable gating
    auto_reload = 1'b0;
    load_valid = 1'b1; load_value = 4'd15; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("clamp_load", 11, 0, 1, 0, 0);
    tick(); chk_all("clamp_en1", 10, 0, 1, 0, 0);
    en = 1'b0;
    tick(); chk_all("clamp_en0", 10, 0, 1, 0, 0);
    en = 1'b1;
    tick(); chk_all("clamp_en1b", 9, 0, 1, 0, 0);

    // Load while running is ignored
    en = 1'b0; load_valid = 1'b1; load_value = 4'd3;
    tick();
    load_valid = 1'b0;
    chk_all("run_load_ignored", 9, 0, 1, 0, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("stop_to_idle", 9, 0, 0, 0, 1);

    // Stop together with load
    load_valid = 1'b1; load_value = 4'd7; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("sl_load7", 7, 0, 1, 0, 0);
    for (int i = 6; i >= 4; i--) begin
      tick();
      chk_all($sformatf("sl_cnt%0d", i), i, 0, 1, 0, 0);
    end
    stop = 1'b1; load_valid = 1'b1; load_value = 4'd3;
    tick();
    stop = 1'b0;
    chk_all("sl_stop_wins", 4, 0, 0, 0, 1);
    tick();
    load_valid = 1'b0;
    chk_all("sl_reload3", 3, 0, 1, 0, 0);

    // Mid-run reset
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("mr_idle", 3, 0, 0, 0, 1);
    load_valid = 1'b1; load_value = 4'd9; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("mr_load9", 9, 0, 1, 0, 0);
    for (int i = 8; i >= 5; i--) begin
      tick();
      chk_all($sformatf("mr_cnt%0d", i), i, 0, 1, 0, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mr_reset", 0, 0, 0, 0, 1);

    // Load of 0 terminates on the first enabled edge
    load_valid = 1'b1; load_value = 4'd0; en = 1'b1; auto_reload = 1'b0;
    tick();
    load_valid = 1'b0;
    chk_all("zero_load", 0, 0, 1, 0, 0);
    tick();
    chk_all("zero_tc", 0, 1, 0, 1, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("done_ignores_stop", 0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod_n_down_timer

`default_nettype wire
